// File: rtl/clock_pkg.sv
// Shared definitions for the clock-ratio checking logic: FSM state encodings
// and the default period-counter width.
package clock_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_ERR     = 2'd3;

endpackage

// File: rtl/clock_ratio_monitor_edge_sync.sv
// Samples div_in and produces a one-cycle rise strobe. With CLK_RATIO_SYNC_EN
// defined, a metastability flop precedes the sampling flop for async inputs.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic div_in,
  output logic rise
);

  logic s_q;
  logic s_dly_q;

`ifdef CLK_RATIO_SYNC_EN
  logic meta_q;

  // meta_q and s_q together form the two-flop synchronizer; s_q doubles as the
  // sampled value, so the extra latency is exactly one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      meta_q  <= div_in;
      s_q     <= meta_q;
      s_dly_q <= s_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      s_q     <= div_in;
      s_dly_q <= s_q;
    end
  end
`endif

  assign rise = s_q & ~s_dly_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures the period of div_in in clk cycles, locks after LOCK_COUNT matching
// periods and flags loss of lock. Optional input synchronizer: CLK_RATIO_SYNC_EN.
module clock_ratio_monitor
  import clock_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EXP_RATIO  = 16,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             clr,
  output logic [CNT_W-1:0] ratio,
  output logic             ratio_valid,
  output logic             locked,
  output logic             err
);

  localparam logic [CNT_W-1:0] SAT  = '1;
  localparam logic [CNT_W-1:0] EXP  = CNT_W'(EXP_RATIO);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [3:0]       LOCK = 4'(LOCK_COUNT);

  logic rise;

  edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .div_in (div_in),
    .rise   (rise)
  );

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mcnt_q, mcnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             sat;
  logic             match;
  logic [CNT_W-1:0] cnt_run;

  assign sat     = (cnt_q == SAT);
  assign match   = (cnt_q == EXP);
  assign cnt_run = rise ? ONE : (sat ? cnt_q : cnt_q + ONE);

  // NOTE: every always_comb output gets a default first so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    ratio_d = ratio_q;
    valid_d = 1'b0;

    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      mcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_MEASURE;
            cnt_d   = ONE;
            mcnt_d  = '0;
          end
        end
        ST_MEASURE: begin
          cnt_d = cnt_run;
          if (sat) begin
            // A stuck input before lock is not an error; just start over.
            state_d = ST_IDLE;
            cnt_d   = '0;
            mcnt_d  = '0;
          end else if (rise) begin
            ratio_d = cnt_q;
            valid_d = 1'b1;
            if (!match) begin
              mcnt_d = '0;
            end else if (4'(mcnt_q + 4'd1) == LOCK) begin
              state_d = ST_LOCKED;
              mcnt_d  = '0;
            end else begin
              mcnt_d = mcnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          cnt_d = cnt_run;
          if (sat) begin
            state_d = ST_ERR;
            mcnt_d  = '0;
          end else if (rise) begin
            ratio_d = cnt_q;
            valid_d = 1'b1;
            if (!match) begin
              state_d = ST_ERR;
              mcnt_d  = '0;
            end
          end
        end
        default: begin
          // ERR keeps measuring so the offending period stays visible.
          cnt_d = cnt_run;
          if (rise && !sat) begin
            ratio_d = cnt_q;
            valid_d = 1'b1;
          end
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
    err_d    = (state_d == ST_ERR);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // is asynchronous so outputs clear without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcnt_q   <= '0;
      ratio_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcnt_q   <= mcnt_d;
      ratio_q  <= ratio_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign ratio       = ratio_q;
  assign ratio_valid = valid_q;
  assign locked      = locked_q;
  assign err         = err_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed bench for clock_ratio_monitor: a table of input periods with the
// pulse each window should show, plus stuck-input and async-reset sequences.
module tb_clock_ratio_monitor;

`ifdef CLK_RATIO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 29;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       div_in = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] ratio;
  logic       ratio_valid;
  logic       locked;
  logic       err;

  int n_vec  = 0;
  int n_miss = 0;

  // One record per input period: the window starts with div_in rising. The
  // expected pulse inside the window reports the previous window's length.
  typedef struct {
    int         period;
    bit         clr_before;
    bit         exp_valid;
    logic [7:0] exp_ratio;
    bit         exp_locked;
    bit         exp_err;
  } vec_t;

  vec_t vecs [NV];

  clock_ratio_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .div_in      (div_in),
    .clr         (clr),
    .ratio       (ratio),
    .ratio_valid (ratio_valid),
    .locked      (locked),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int p, input bit c, input bit v,
                              input logic [7:0] r, input bit l, input bit e);
    vec_t t;
    t.period = p; t.clr_before = c; t.exp_valid = v;
    t.exp_ratio = r; t.exp_locked = l; t.exp_err = e;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic d, input logic c);
    div_in = d;
    clr    = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_window(input vec_t v, input int idx);
    int         pulses = 0;
    int         pos = -1;
    logic [7:0] r = '0;
    logic       l = 1'b0;
    logic       e = 1'b0;
    if (v.clr_before) begin
      step(1'b0, 1'b1);
      check($sformatf("v%0d clr err", idx), 32'(err), 32'd0);
      check($sformatf("v%0d clr locked", idx), 32'(locked), 32'd0);
    end
    for (int i = 0; i < v.period; i++) begin
      step(i < v.period / 2, 1'b0);
      if (ratio_valid) begin
        pulses++;
        pos = i;
        r = ratio;
        l = locked;
        e = err;
      end
    end
    if (!v.exp_valid) begin
      l = locked;
      e = err;
    end
    check($sformatf("v%0d pulses", idx), 32'(pulses), v.exp_valid ? 32'd1 : 32'd0);
    if (v.exp_valid) begin
      check($sformatf("v%0d ratio", idx), 32'(r), 32'(v.exp_ratio));
      check($sformatf("v%0d latency", idx), 32'(pos), 32'(LAT));
    end
    check($sformatf("v%0d locked", idx), 32'(l), 32'(v.exp_locked));
    check($sformatf("v%0d err", idx), 32'(e), 32'(v.exp_err));
  endtask

  initial begin
    // Lock on /16, lose it to /8, ERR keeps measuring.
    vecs[0]  = mk(16, 0, 0, 8'd0,  0, 0);
    vecs[1]  = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[2]  = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[3]  = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[4]  = mk(16, 0, 1, 8'd16, 1, 0);
    vecs[5]  = mk(8,  0, 1, 8'd16, 1, 0);
    vecs[6]  = mk(8,  0, 1, 8'd8,  0, 1);
    vecs[7]  = mk(8,  0, 1, 8'd8,  0, 1);
    vecs[8]  = mk(16, 0, 1, 8'd8,  0, 1);
    // clr out of ERR, relock after five edges.
    vecs[9]  = mk(16, 1, 0, 8'd0,  0, 0);
    vecs[10] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[11] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[12] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[13] = mk(16, 0, 1, 8'd16, 1, 0);
    // Periods 16,16,15,16,16,16,16: lock only on the 7th pulse.
    vecs[14] = mk(16, 1, 0, 8'd0,  0, 0);
    vecs[15] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[16] = mk(15, 0, 1, 8'd16, 0, 0);
    vecs[17] = mk(16, 0, 1, 8'd15, 0, 0);
    vecs[18] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[19] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[20] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[21] = mk(16, 0, 1, 8'd16, 1, 0);
    // Off-by-one long period while locked.
    vecs[22] = mk(17, 0, 1, 8'd16, 1, 0);
    vecs[23] = mk(16, 0, 1, 8'd17, 0, 1);
    // Relock for the reset test.
    vecs[24] = mk(16, 1, 0, 8'd0,  0, 0);
    vecs[25] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[26] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[27] = mk(16, 0, 1, 8'd16, 0, 0);
    vecs[28] = mk(16, 0, 1, 8'd16, 1, 0);

    repeat (3) @(negedge clk);
    check("reset ratio", 32'(ratio), 32'd0);
    check("reset valid", 32'(ratio_valid), 32'd0);
    check("reset locked", 32'(locked), 32'd0);
    check("reset err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_window(vecs[i], i);

    // Asynchronous reset in the middle of a locked period.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre-reset ratio", 32'(ratio), 32'd16);
    #2 rst = 1'b0;
    #1;
    check("async rst ratio", 32'(ratio), 32'd0);
    check("async rst valid", 32'(ratio_valid), 32'd0);
    check("async rst locked", 32'(locked), 32'd0);
    check("async rst err", 32'(err), 32'd0);
    div_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_window(mk(16, 0, 0, 8'd0, 0, 0), 100);
    for (int i = 0; i < 4; i++) run_window(mk(16, 0, 1, 8'd16, i == 3, 0), 101 + i);

    // Stuck-low input while locked: err exactly 255 edges after the last rise.
    for (int i = 0; i <= LAT + 255; i++) begin
      step(i < 8, 1'b0);
      if (i == LAT) check("stuck last ratio", 32'(ratio), 32'd16);
      if (i == LAT + 254) begin
        check("stuck err before sat", 32'(err), 32'd0);
        check("stuck locked before sat", 32'(locked), 32'd1);
      end
      if (i == LAT + 255) begin
        check("stuck err at sat", 32'(err), 32'd1);
        check("stuck locked at sat", 32'(locked), 32'd0);
      end
    end
    step(1'b0, 1'b0);
    check("stuck err sticky", 32'(err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
